// File: rtl/vm_pkg.sv
// Shared constants and FSM state encoding for the vm_multi vending controller.
// No ports: imported by vm_table and vm_multi.
package vm_pkg;

    localparam int MONEY_W_DEF = 10;
    localparam int SEL_W_DEF   = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CREDIT = 3'd1;
    localparam logic [2:0] ST_VEND   = 3'd2;
    localparam logic [2:0] ST_CHANGE = 3'd3;
    localparam logic [2:0] ST_MAINT  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        CREDIT = ST_CREDIT,
        VEND   = ST_VEND,
        CHANGE = ST_CHANGE,
        MAINT  = ST_MAINT
    } vm_state_e;

endpackage

// File: rtl/vm_table.sv
// Per-product price/stock register file for the vending controller.
// Ports: clk/rst, combinational read (rd_idx_i -> rd_price_o/rd_stock_o),
// maintenance write (wr_en_i, wr_idx_i, wr_price_i, wr_stock_i),
// vend decrement (dec_en_i, dec_idx_i).
module vm_table
    import vm_pkg::*;
#(
    parameter int N_PROD    = 32,
    parameter int SEL_W     = SEL_W_DEF,
    parameter int MONEY_W   = MONEY_W_DEF,
    parameter int STOCK_W   = 4,
    parameter int DEF_PRICE = 10,
    parameter int DEF_STOCK = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   rd_idx_i,
    output logic [MONEY_W-1:0] rd_price_o,
    output logic [STOCK_W-1:0] rd_stock_o,
    input  logic               wr_en_i,
    input  logic [SEL_W-1:0]   wr_idx_i,
    input  logic [MONEY_W-1:0] wr_price_i,
    input  logic [STOCK_W-1:0] wr_stock_i,
    input  logic               dec_en_i,
    input  logic [SEL_W-1:0]   dec_idx_i
);

    logic [MONEY_W-1:0] price_q [N_PROD];
    logic [STOCK_W-1:0] stock_q [N_PROD];

    // Out-of-range indices read as price 0 / stock 0.
    always_comb begin
        rd_price_o = '0;
        rd_stock_o = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (rd_idx_i == SEL_W'(i)) begin
                rd_price_o = price_q[i];
                rd_stock_o = stock_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PROD; i++) begin
                price_q[i] <= MONEY_W'(DEF_PRICE);
                stock_q[i] <= STOCK_W'(DEF_STOCK);
            end
        end else begin
            for (int i = 0; i < N_PROD; i++) begin
                if (wr_en_i && wr_idx_i == SEL_W'(i)) begin
                    price_q[i] <= wr_price_i;
                    stock_q[i] <= wr_stock_i;
                end else if (dec_en_i && dec_idx_i == SEL_W'(i)
                             && stock_q[i] != '0) begin
                    // Stock saturates at zero, never wraps.
                    stock_q[i] <= stock_q[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vm_multi.sv
// Multi-product vending controller: credit, vend, change, maintenance.
// Ports: coin (deposit/deposited), keypad (select/selected), maintenance
// writes (price/stock_in), cancel/maintenance levels; pulses refund,
// refundall, depositall, vend, soldout; held product/change; credit, state.
module vm_multi
    import vm_pkg::*;
#(
    parameter int N_PROD     = 32,
    parameter int SEL_W      = SEL_W_DEF,
    parameter int MONEY_W    = MONEY_W_DEF,
    parameter int CREDIT_MAX = 500,
    parameter int STOCK_W    = 4,
    parameter int DEF_PRICE  = 10,
    parameter int DEF_STOCK  = 8,
    parameter int MULTI_VEND = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MONEY_W-1:0] deposit,
    input  logic               deposited,
    input  logic [SEL_W-1:0]   select,
    input  logic               selected,
    input  logic [MONEY_W-1:0] price,
    input  logic [STOCK_W-1:0] stock_in,
    input  logic               cancel,
    input  logic               maintenance,
    output logic               refund,
    output logic               refundall,
    output logic               depositall,
    output logic               vend,
    output logic               soldout,
    output logic [SEL_W-1:0]   product,
    output logic [MONEY_W-1:0] change,
    output logic [MONEY_W-1:0] credit,
    output logic [2:0]         state
);

    vm_state_e          state_q;
    logic               dep_q, sel_q;
    logic               refund_q, refundall_q, depositall_q;
    logic               vend_q, soldout_q;
    logic [SEL_W-1:0]   product_q;
    logic [MONEY_W-1:0] change_q, credit_q;

    logic               dep_edge, sel_edge, sel_ok;
    logic               pre_d, take_d, rej_d, buy_d, wr_d, pay_d;
    logic [MONEY_W:0]   sum_d;
    logic [MONEY_W-1:0] price_rd;
    logic [STOCK_W-1:0] stock_rd;

    vm_table #(
        .N_PROD   (N_PROD),
        .SEL_W    (SEL_W),
        .MONEY_W  (MONEY_W),
        .STOCK_W  (STOCK_W),
        .DEF_PRICE(DEF_PRICE),
        .DEF_STOCK(DEF_STOCK)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (select),
        .rd_price_o(price_rd),
        .rd_stock_o(stock_rd),
        .wr_en_i   (wr_d),
        .wr_idx_i  (select),
        .wr_price_i(price),
        .wr_stock_i(stock_in),
        .dec_en_i  (buy_d),
        .dec_idx_i (select)
    );

    always_comb begin
        dep_edge = deposited & ~dep_q;
        sel_edge = selected & ~sel_q;
        sel_ok   = 32'(select) < 32'(N_PROD);
        sum_d    = {1'b0, credit_q} + {1'b0, deposit};
        // A coin is preempted by any higher-priority event that cycle.
        pre_d    = cancel | maintenance
                 | (sel_edge & (state_q == CREDIT));
        take_d   = dep_edge && (deposit != '0) && !pre_d
                 && (state_q == IDLE || state_q == CREDIT)
                 && (sum_d <= (MONEY_W+1)'(CREDIT_MAX));
        // Any real coin that is not credited goes straight back.
        rej_d    = dep_edge && (deposit != '0) && !take_d;
        buy_d    = (state_q == CREDIT) && !cancel && !maintenance
                 && sel_edge && sel_ok && (stock_rd != '0)
                 && (credit_q >= price_rd);
        wr_d     = (state_q == MAINT) && maintenance && sel_edge
                 && sel_ok && (price != '0);
        pay_d    = ((state_q == CREDIT) && (cancel || maintenance))
                 || ((state_q == VEND) && (MULTI_VEND == 0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dep_q        <= 1'b0;
            sel_q        <= 1'b0;
            refund_q     <= 1'b0;
            refundall_q  <= 1'b0;
            depositall_q <= 1'b0;
            vend_q       <= 1'b0;
            soldout_q    <= 1'b0;
            product_q    <= '0;
            change_q     <= '0;
            credit_q     <= '0;
        end else begin
            dep_q        <= deposited;
            sel_q        <= selected;
            refund_q     <= rej_d;
            refundall_q  <= 1'b0;
            depositall_q <= 1'b0;
            vend_q       <= 1'b0;
            soldout_q    <= 1'b0;
            if (take_d) begin
                credit_q <= sum_d[MONEY_W-1:0];
            end
            // Payout happens on entry to CHANGE.
            if (pay_d) begin
                change_q    <= credit_q;
                refundall_q <= (credit_q != '0);
                credit_q    <= '0;
            end
            // Vend pulses are issued on entry to VEND.
            if (buy_d) begin
                vend_q       <= 1'b1;
                depositall_q <= 1'b1;
                product_q    <= select;
                credit_q     <= credit_q - price_rd;
            end
            unique case (state_q)
                IDLE: begin
                    if (maintenance) begin
                        state_q <= MAINT;
                    end else if (take_d) begin
                        state_q <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (pay_d) begin
                        state_q <= CHANGE;
                    end else if (buy_d) begin
                        state_q <= VEND;
                    end else if (sel_edge && sel_ok
                                 && stock_rd == '0) begin
                        soldout_q <= 1'b1;
                    end
                end
                VEND: begin
                    if (pay_d) begin
                        state_q <= CHANGE;
                    end else begin
                        state_q <= (credit_q != '0) ? CREDIT : IDLE;
                    end
                end
                CHANGE: begin
                    state_q <= maintenance ? MAINT : IDLE;
                end
                MAINT: begin
                    if (!maintenance) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign refund     = refund_q;
    assign refundall  = refundall_q;
    assign depositall = depositall_q;
    assign vend       = vend_q;
    assign soldout    = soldout_q;
    assign product    = product_q;
    assign change     = change_q;
    assign credit     = credit_q;
    assign state      = state_q;

endmodule

// File: doc/vm_multi.md
Name: vm_multi

Overview:
- Parametrised next-generation vending machine controller: N_PROD products, configurable money width and credit ceiling.
- Adds per-product stock counts, sold-out reporting, and an optional multi-vend mode that keeps leftover credit after a purchase.
- Sits between the coin/keypad front-end strobes and the dispenser and changer actuators.
- Price and stock tables are written in maintenance mode.

Parameters:
- N_PROD, 32, number of products; valid range 2..2**SEL_W.
- SEL_W, 5, select/product index width.
- MONEY_W, 10, width of deposit, price, change and credit.
- CREDIT_MAX, 500, maximum accumulated credit; must be < 2**MONEY_W.
- STOCK_W, 4, stock counter width.
- DEF_PRICE, 10, price of every product after reset.
- DEF_STOCK, 8, stock of every product after reset.
- MULTI_VEND, 0, 0 = change returned after each vend; 1 = credit retained until cancel.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- deposit  in  MONEY_W  coin/note value, valid with deposited.
- deposited  in  1  deposit strobe; rising edge = one coin.
- select  in  SEL_W  product index, valid with selected.
- selected  in  1  select strobe; rising edge = one request.
- price  in  MONEY_W  new price, used in maintenance only.
- stock_in  in  STOCK_W  new stock, used in maintenance only.
- cancel  in  1  level; return all credit.
- maintenance  in  1  level; maintenance mode.
- refund  out  1  1-cycle pulse: the current coin is rejected and returned.
- refundall  out  1  1-cycle pulse: change is paid out.
- depositall  out  1  1-cycle pulse: price moved to the cashbox.
- vend  out  1  1-cycle pulse: product is dispensed.
- soldout  out  1  1-cycle pulse: selected product has stock 0.
- product  out  SEL_W  index of the dispensed product; held until the next vend.
- change  out  MONEY_W  amount paid with refundall; held until the next payout.
- credit  out  MONEY_W  current accumulated credit.
- state  out  3  FSM state (debug).

Behaviour:
- Reset (async, immediate):
  - state IDLE; all outputs 0.
  - Every price = DEF_PRICE; every stock = DEF_STOCK.
  - Strobe edge detectors cleared.
- Strobes: deposited and selected are edge-detected, so each 0->1 counts once. A strobe held high does not repeat.
- Latency: response outputs are registered and appear in the cycle after the clock edge that first samples the strobe high.
- FSM states: IDLE=0, CREDIT=1, VEND=2, CHANGE=3, MAINT=4.
- IDLE / CREDIT, deposit edge:
  - Sum formed in MONEY_W+1 bits.
  - If credit+deposit > CREDIT_MAX: refund pulses, credit unchanged.
  - Otherwise credit += deposit and state goes to CREDIT.
  - deposit=0 is ignored.
- CREDIT, select edge:
  - select >= N_PROD: ignored.
  - stock==0: soldout pulses, state stays.
  - credit < price[select]: ignored.
  - Otherwise go to VEND.
- VEND (1 cycle):
  - vend and depositall pulse; product=select.
  - stock decremented; credit -= price.
  - MULTI_VEND=0: next state CHANGE.
  - MULTI_VEND=1: next state CREDIT if credit>0, otherwise IDLE.
- CHANGE (1 cycle):
  - change=credit, refundall pulses, credit=0.
  - Next state MAINT if maintenance=1, otherwise IDLE.
  - When credit is 0, change=0 and there is no refundall pulse.
- cancel in CREDIT: go to CHANGE.
- Priority for events in the same cycle: cancel > maintenance > select > deposit.
- maintenance asserted:
  - From IDLE: go to MAINT.
  - From CREDIT: go through CHANGE first (auto-refund), then MAINT.
  - From VEND: VEND completes first.
- MAINT:
  - Select edge with select < N_PROD writes price[select]=price and stock[select]=stock_in.
  - price=0 or select out of range: the whole write is ignored.
  - Deposit edges produce a refund pulse.
  - cancel has no effect.
  - Deassert maintenance: go to IDLE.
- Stock never wraps: decrement happens only when stock > 0.

Decomposition:
- Package vm_pkg holds:
  - state localparams (IDLE..MAINT);
  - the MONEY_W / SEL_W default constants.
- Sub-module vm_table: price/stock register file with parameters N_PROD, SEL_W, MONEY_W, STOCK_W.
  - One combinational read port.
  - One write port (maintenance).
  - One decrement port (vend).
  - Async reset to the defaults.
- vm_multi contains the FSM, edge detectors and credit arithmetic.

Test Plan:
1. Defaults. Deposits 100, 200, 200, 1 with edges between them -> credit 100, 300, 500, 500. The 4th coin gives one refund pulse; state=1.
2. Cancel held for 2 cycles -> single refundall pulse, change=500, credit=0, state IDLE.
3. Default config. Deposits 10, 100, 20 (credit 130), then select 10 -> vend, depositall, product=10, stock[10]=7. Next cycle: refundall, change=120, credit=0.
4. Maintenance writes:
   - select 30, price 2, stock_in 1 -> writes.
   - select 31, price 0 -> ignored; price[31] stays 10.
   - Deposit 50 during MAINT -> refund pulse.
5. MULTI_VEND=1, price[30]=2, stock[30]=1, price[3]=20. Deposits 200, 100, 100 (credit 400).
   - select 30 -> credit 398, stock[30]=0.
   - select 30 again -> soldout pulse, credit 398.
   - select 3 -> credit 378.
   - cancel -> change=378.
6. Assert rst mid-CREDIT (credit 130) between clock edges -> credit, state and pulses are 0 immediately. After release, price[30]=10 and stock[30]=8.
